// File: rtl/sprite_layer_sequencer.sv
// Per-pixel sprite compositor controller: walks the sprites covering a pixel in priority order
// through one shared ROM port, skipping transparent texels, with the arena background as fallback.
module sprite_layer_sequencer #(
    parameter int unsigned NUM_SPR     = 8,
    parameter int unsigned SPR_W       = 20,
    parameter logic [17:0] TRANSPARENT = 18'h00001
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [9:0]            req_x,
    input  logic [9:0]            req_y,
    input  logic [NUM_SPR-1:0]    spr_en,
    input  logic [10*NUM_SPR-1:0] spr_x,
    input  logic [10*NUM_SPR-1:0] spr_y,
    input  logic [2*NUM_SPR-1:0]  spr_dir,
    output logic                  rom_en,
    output logic [3:0]            rom_sel,
    output logic [9:0]            rom_x,
    output logic [9:0]            rom_y,
    output logic [1:0]            rom_dir,
    input  logic [17:0]           rom_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [17:0]           out_pixel,
    output logic [3:0]            out_layer
);

    localparam logic [3:0]  BG_SEL = 4'(NUM_SPR);
    localparam logic [10:0] SPR_W11 = 11'(SPR_W);

    typedef enum logic [2:0] {StIdle, StHit, StIssue, StData, StDone} state_e;

    state_e state_q, state_d;

    logic [9:0]            req_x_q, req_y_q;
    logic [NUM_SPR-1:0]    spr_en_q;
    logic [10*NUM_SPR-1:0] spr_x_q, spr_y_q;
    logic [2*NUM_SPR-1:0]  spr_dir_q;
    logic [NUM_SPR-1:0]    mask_q, mask_d, hit;

    logic        rom_en_q, rom_en_d;
    logic [3:0]  rom_sel_q, rom_sel_d;
    logic [9:0]  rom_x_q, rom_x_d, rom_y_q, rom_y_d;
    logic [1:0]  rom_dir_q, rom_dir_d;
    logic [17:0] out_pixel_q, out_pixel_d;
    logic [3:0]  out_layer_q, out_layer_d;
    logic        accept;

    assign accept    = (state_q == StIdle) && req_valid;
    assign req_ready = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign rom_en    = rom_en_q;
    assign rom_sel   = rom_sel_q;
    assign rom_x     = rom_x_q;
    assign rom_y     = rom_y_q;
    assign rom_dir   = rom_dir_q;
    assign out_pixel = out_pixel_q;
    assign out_layer = out_layer_q;

    // Bounds are compared in 11 bits so a sprite near the right/bottom edge never wraps to 0.
    always_comb begin
        hit = '0;
        for (int i = 0; i < NUM_SPR; i++) begin
            hit[i] = spr_en_q[i]
                & ({1'b0, req_x_q} >= {1'b0, spr_x_q[10*i +: 10]})
                & ({1'b0, req_x_q} <  ({1'b0, spr_x_q[10*i +: 10]} + SPR_W11))
                & ({1'b0, req_y_q} >= {1'b0, spr_y_q[10*i +: 10]})
                & ({1'b0, req_y_q} <  ({1'b0, spr_y_q[10*i +: 10]} + SPR_W11));
        end
    end

    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        rom_en_d    = 1'b0;
        rom_sel_d   = rom_sel_q;
        rom_x_d     = rom_x_q;
        rom_y_d     = rom_y_q;
        rom_dir_d   = rom_dir_q;
        out_pixel_d = out_pixel_q;
        out_layer_d = out_layer_q;

        unique case (state_q)
            StIdle: begin
                if (req_valid) state_d = StHit;
            end
            StHit: begin
                mask_d  = hit;
                state_d = StIssue;
            end
            StIssue: begin
                state_d = StData;
            end
            StData: begin
                if (rom_sel_q == BG_SEL || rom_data != TRANSPARENT) begin
                    out_pixel_d = rom_data;
                    out_layer_d = rom_sel_q;
                    state_d     = StDone;
                end else begin
                    for (int i = 0; i < NUM_SPR; i++) begin
                        if (4'(i) == rom_sel_q) mask_d[i] = 1'b0;
                    end
                    state_d = StIssue;
                end
            end
            StDone: begin
                if (out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // The ROM address is registered on entry to ISSUE; descending loop leaves the lowest hit.
        if (state_d == StIssue) begin
            rom_en_d  = 1'b1;
            rom_sel_d = BG_SEL;
            rom_x_d   = req_x_q;
            rom_y_d   = req_y_q;
            rom_dir_d = 2'b00;
            for (int i = NUM_SPR - 1; i >= 0; i--) begin
                if (mask_d[i]) begin
                    rom_sel_d = 4'(i);
                    rom_x_d   = req_x_q - spr_x_q[10*i +: 10];
                    rom_y_d   = req_y_q - spr_y_q[10*i +: 10];
                    rom_dir_d = spr_dir_q[2*i +: 2];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            mask_q      <= '0;
            rom_en_q    <= 1'b0;
            rom_sel_q   <= '0;
            rom_x_q     <= '0;
            rom_y_q     <= '0;
            rom_dir_q   <= '0;
            out_pixel_q <= '0;
            out_layer_q <= '0;
            req_x_q     <= '0;
            req_y_q     <= '0;
            spr_en_q    <= '0;
            spr_x_q     <= '0;
            spr_y_q     <= '0;
            spr_dir_q   <= '0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            rom_en_q    <= rom_en_d;
            rom_sel_q   <= rom_sel_d;
            rom_x_q     <= rom_x_d;
            rom_y_q     <= rom_y_d;
            rom_dir_q   <= rom_dir_d;
            out_pixel_q <= out_pixel_d;
            out_layer_q <= out_layer_d;
            if (accept) begin
                req_x_q   <= req_x;
                req_y_q   <= req_y;
                spr_en_q  <= spr_en;
                spr_x_q   <= spr_x;
                spr_y_q   <= spr_y;
                spr_dir_q <= spr_dir;
            end
        end
    end

endmodule

// File: tb/tb_sprite_layer_sequencer.sv
// Scoreboard bench: stimulus queues expected ROM reads and composited pixels, a monitor checks them.
module tb_sprite_layer_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [9:0]  req_x, req_y;
    logic [7:0]  spr_en;
    logic [79:0] spr_x, spr_y;
    logic [15:0] spr_dir;
    logic        rom_en;
    logic [3:0]  rom_sel;
    logic [9:0]  rom_x, rom_y;
    logic [1:0]  rom_dir;
    logic [17:0] rom_data;
    logic        out_valid;
    logic        out_ready;
    logic [17:0] out_pixel;
    logic [3:0]  out_layer;

    sprite_layer_sequencer dut (
        .clk      (clk),
        .reset    (reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_x    (req_x),
        .req_y    (req_y),
        .spr_en   (spr_en),
        .spr_x    (spr_x),
        .spr_y    (spr_y),
        .spr_dir  (spr_dir),
        .rom_en   (rom_en),
        .rom_sel  (rom_sel),
        .rom_x    (rom_x),
        .rom_y    (rom_y),
        .rom_dir  (rom_dir),
        .rom_data (rom_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_pixel(out_pixel),
        .out_layer(out_layer)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] sel;
        logic [9:0] x;
        logic [9:0] y;
        logic [1:0] dir;
    } rd_t;

    typedef struct {
        logic [17:0] pix;
        logic [3:0]  layer;
        int          lat;
    } px_t;

    rd_t rq[$];
    px_t pq[$];

    logic [17:0] tex [0:8];
    int total = 0;
    int bad = 0;

    // ROM bank model: texel appears one cycle after the strobe.
    always @(posedge clk) begin
        if (rom_en) rom_data <= tex[rom_sel];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor
    int  ncyc = 0;
    int  acc_cyc = 0;
    bit  prev_ov = 0;
    bit  chk_rdy = 0;
    always @(negedge clk) begin
        rd_t r;
        px_t e;
        if (reset) begin
            prev_ov = 0;
            chk_rdy = 0;
        end else begin
            if (rom_en) begin
                if (rq.size() == 0) begin
                    check("rom_unexpected", 1, 0);
                end else begin
                    r = rq.pop_front();
                    check("rom_sel", 32'(rom_sel), 32'(r.sel));
                    check("rom_x", 32'(rom_x), 32'(r.x));
                    check("rom_y", 32'(rom_y), 32'(r.y));
                    check("rom_dir", 32'(rom_dir), 32'(r.dir));
                end
            end
            if (out_valid) begin
                if (pq.size() == 0) begin
                    check("out_unexpected", 1, 0);
                end else begin
                    e = pq[0];
                    if (!prev_ov) check("latency", 32'(ncyc - acc_cyc), 32'(e.lat));
                    check("out_pixel", 32'(out_pixel), 32'(e.pix));
                    check("out_layer", 32'(out_layer), 32'(e.layer));
                    check("req_ready_busy", 32'(req_ready), 0);
                    if (out_ready) begin
                        void'(pq.pop_front());
                        chk_rdy = 1;
                    end
                end
            end else if (chk_rdy) begin
                check("req_ready_after", 32'(req_ready), 1);
                chk_rdy = 0;
            end
            prev_ov = out_valid;
            if (req_valid && req_ready) acc_cyc = ncyc;
        end
        ncyc++;
    end

    task automatic set_spr(input int i, input logic [9:0] x, input logic [9:0] y,
                           input logic [1:0] d);
        spr_en[i]          = 1'b1;
        spr_x[10*i +: 10]  = x;
        spr_y[10*i +: 10]  = y;
        spr_dir[2*i +: 2]  = d;
    endtask

    task automatic push_rd(input logic [3:0] s, input logic [9:0] x, input logic [9:0] y,
                           input logic [1:0] d);
        rd_t r;
        r.sel = s; r.x = x; r.y = y; r.dir = d;
        rq.push_back(r);
    endtask

    task automatic push_px(input logic [17:0] p, input logic [3:0] l, input int lat);
        px_t e;
        e.pix = p; e.layer = l; e.lat = lat;
        pq.push_back(e);
    endtask

    // Sprite inputs are scrambled right after acceptance to prove they were latched.
    task automatic send(input logic [9:0] x, input logic [9:0] y);
        check("req_ready_idle", 32'(req_ready), 1);
        req_x = x;
        req_y = y;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        spr_en = '1;
        spr_x = '1;
        spr_y = '1;
        spr_dir = '1;
    endtask

    task automatic drain();
        int n = 0;
        while (!(pq.size() == 0 && rq.size() == 0 && req_ready) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", 32'(pq.size() == 0 && rq.size() == 0 && req_ready), 1);
        @(negedge clk);
        @(posedge clk);
        #1;
        spr_en = '0;
    endtask

    initial begin
        int n;
        reset = 1'b1;
        req_valid = 1'b0;
        req_x = '0;
        req_y = '0;
        spr_en = '0;
        spr_x = '0;
        spr_y = '0;
        spr_dir = '0;
        out_ready = 1'b1;
        rom_data = '0;
        for (int i = 0; i < 9; i++) tex[i] = 18'h00001;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 1);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_rom_en", 32'(rom_en), 0);
        check("rst_rom_sel", 32'(rom_sel), 0);
        check("rst_rom_xy", 32'({rom_x, rom_y, rom_dir}), 0);
        check("rst_out", 32'({out_pixel, out_layer}), 0);
        @(posedge clk);
        #1;

        // Background only
        tex[8] = 18'h0ABCD;
        push_rd(8, 5, 7, 0);
        push_px(18'h0ABCD, 8, 4);
        send(5, 7);
        drain();

        // Single opaque sprite
        set_spr(3, 100, 50, 2);
        tex[3] = 18'h12345;
        push_rd(3, 5, 19, 2);
        push_px(18'h12345, 3, 4);
        send(105, 69);
        drain();

        // Overlap: sprite 1 transparent, sprite 4 opaque
        set_spr(1, 200, 100, 1);
        set_spr(4, 195, 95, 3);
        tex[1] = 18'h00001;
        tex[4] = 18'h00F00;
        push_rd(1, 10, 10, 1);
        push_rd(4, 15, 15, 3);
        push_px(18'h00F00, 4, 6);
        send(210, 110);
        drain();

        // Right edge exclusive; transparent background still accepted
        set_spr(0, 10, 10, 1);
        tex[8] = 18'h00001;
        push_rd(8, 30, 15, 0);
        push_px(18'h00001, 8, 4);
        send(30, 15);
        drain();

        // Last covered column
        set_spr(0, 10, 10, 1);
        tex[0] = 18'h2AAAA;
        push_rd(0, 19, 5, 1);
        push_px(18'h2AAAA, 0, 4);
        send(29, 15);
        drain();

        // No wrap for a sprite near x=1023
        set_spr(2, 1015, 0, 3);
        tex[8] = 18'h33333;
        push_rd(8, 3, 5, 0);
        push_px(18'h33333, 8, 4);
        send(3, 5);
        drain();

        // Worst case: all eight sprites transparent, then background
        for (int i = 0; i < 8; i++) begin
            set_spr(i, 300, 300, 2'(i));
            tex[i] = 18'h00001;
            push_rd(4'(i), 5, 6, 2'(i));
        end
        tex[8] = 18'h01234;
        push_rd(8, 305, 306, 0);
        push_px(18'h01234, 8, 20);
        send(305, 306);
        drain();

        // Output stall for 5 cycles
        tex[8] = 18'h0BEEF;
        push_rd(8, 40, 41, 0);
        push_px(18'h0BEEF, 8, 4);
        send(40, 41);
        out_ready = 1'b0;
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk);
            n++;
        end
        check("stall_reach_done", 32'(out_valid), 1);
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain();

        // Reset during DATA discards the pixel
        tex[8] = 18'h05555;
        push_rd(8, 7, 8, 0);
        send(7, 8);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_mid_out_valid", 32'(out_valid), 0);
        check("rst_mid_rom_en", 32'(rom_en), 0);
        check("rst_mid_req_ready", 32'(req_ready), 1);
        check("rst_mid_rd_consumed", 32'(rq.size()), 0);
        @(posedge clk);
        #1;

        // Normal request after reset
        tex[8] = 18'h06666;
        push_rd(8, 9, 10, 0);
        push_px(18'h06666, 8, 4);
        send(9, 10);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sprite_layer_sequencer.md
Name: sprite_layer_sequencer

Overview:
- Per-pixel compositor controller for the sprite/arena ROM bank.
- Accepts one screen-pixel request at a time and finds which of NUM_SPR sprites (characters, projectiles) cover that pixel.
- Sequences lookups through one shared sprite-ROM read port in priority order, skipping transparent texels, and falls back to the arena background layer.
- Sits between the display pixel scanner and the sprite ROM mux.

Parameters:
- NUM_SPR, 8, number of sprite layers; index 0 has highest priority.
- SPR_W, 20, sprite width/height in pixels.
- TRANSPARENT, 18'h00001, texel code treated as see-through (also the ROMs' out-of-bounds code).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  pixel request valid.
- req_ready  out  1  sequencer can accept a request.
- req_x  in  10  screen x of requested pixel.
- req_y  in  10  screen y of requested pixel.
- spr_en  in  NUM_SPR  per-sprite enable (alive/active).
- spr_x  in  10*NUM_SPR  packed sprite left edges; sprite i at bits [10i+9:10i].
- spr_y  in  10*NUM_SPR  packed sprite top edges.
- spr_dir  in  2*NUM_SPR  packed facing direction per sprite.
- rom_en  out  1  shared ROM read strobe.
- rom_sel  out  4  layer being read: 0..NUM_SPR-1 = sprite, NUM_SPR = background.
- rom_x  out  10  local x (sprite-relative, or screen x for background).
- rom_y  out  10  local y (sprite-relative, or screen y for background).
- rom_dir  out  2  direction of selected sprite; 0 for background.
- rom_data  in  18  texel returned by selected ROM, one cycle after rom_en.
- out_valid  out  1  composited pixel valid.
- out_ready  in  1  consumer accepts pixel.
- out_pixel  out  18  composited texel.
- out_layer  out  4  layer that supplied out_pixel.

Behaviour:
- Reset values:
  - state IDLE; req_ready=1; out_valid=0; rom_en=0.
  - rom_sel, rom_x, rom_y, rom_dir = 0; out_pixel = 0; out_layer = 0.
  - Hit mask cleared.
- States: IDLE, HIT, ISSUE, DATA, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid: latch req_x/y, spr_en, spr_x, spr_y, spr_dir, then go to HIT.
  - Sprite positions that change after acceptance do not affect the pixel in flight.
- HIT (1 cycle):
  - mask[i] = spr_en[i] & (req_x >= spr_x[i]) & (req_x < spr_x[i]+SPR_W) & (req_y >= spr_y[i]) & (req_y < spr_y[i]+SPR_W).
  - Compute sums in 11 bits; no wrap, so a sprite at x=1015 cannot hit x=3.
  - Go to ISSUE.
- ISSUE (1 cycle):
  - rom_en=1.
  - If mask != 0: rom_sel = lowest set index i, rom_x = req_x - spr_x[i], rom_y = req_y - spr_y[i], rom_dir = spr_dir[i].
  - Otherwise: rom_sel = NUM_SPR, rom_x = req_x, rom_y = req_y, rom_dir = 0.
  - Go to DATA.
- DATA (rom_data valid):
  - If the layer is background, or rom_data != TRANSPARENT: out_pixel = rom_data, out_layer = rom_sel, go to DONE.
  - Otherwise clear that mask bit and go to ISSUE.
  - The background is always accepted, even if it equals TRANSPARENT.
- DONE:
  - out_valid=1; out_pixel and out_layer held stable until out_ready.
  - On out_ready go to IDLE (no same-cycle re-accept).
- rom_en=0 and rom_* hold their last values outside ISSUE.
- Latency: fetching L layers (L≥1, including the final one) gives out_valid in the (2L+2)th cycle after the acceptance edge.
  - Background-only pixel: out_valid 4 cycles after acceptance.
  - Worst case is L = NUM_SPR+1.
- reset asserted in any state: next cycle is IDLE with reset values; an in-flight pixel is discarded with no output.

Test Plan:
- No sprites enabled, req (5,7), rom_data=18'h0ABCD -> rom_sel=8, rom_x=5, rom_y=7 in ISSUE; out_valid 4 cycles after accept; out_pixel=18'h0ABCD, out_layer=8.
- Sprite 3 at (100,50), dir=2, req (105,69), opaque texel 18'h12345 -> rom_sel=3, rom_x=5, rom_y=19, rom_dir=2; out_layer=3, out_pixel=18'h12345.
- Sprites 1 and 4 overlap req; sprite 1 texel=18'h00001, sprite 4 texel=18'h00F00 -> read order 1,4; out_layer=4, out_pixel=18'h00F00, out_valid 6 cycles after accept.
- Edge checks: sprite 0 at (10,10) with req x=30 -> no hit (background); req x=29 -> hit, rom_x=19. Sprite at x=1015 with req x=3 -> no hit.
- out_ready held low 5 cycles in DONE -> out_valid stays 1, out_pixel stable, req_ready=0; release -> IDLE, req_ready=1 next cycle.
- reset pulsed during DATA -> next cycle out_valid=0, rom_en=0, req_ready=1; a new request then completes normally.
